sd_spi_master: RTL and testbench
================================

// Module: sd_spi_master
// PURPOSE
//  fclk-domain SPI master (mode 0, MSB first) that serves the Z80 port block's SD data port (#57).
//  Each one-fclk start pulse, already resynced from the Z80 toggle, launches one 8-bit exchange.
//  The exchange shifts datain out on sdo and shifts sdi into dataout.
//  Sits between the port decoder and the SD card pins; sdcs_n stays in the port decoder.
// PARAMETERS
//  HALF_DIV  1  fclk cycles per SCK half-period, >=1 (default gives SCK = fclk/2)
// PORTS
//  fclk      in   1  FPGA clock; only clock of the block
//  rst_n     in   1  reset, asynchronous, active-low
//  start     in   1  one-fclk pulse: begin exchange
//  datain    in   8  byte to transmit; 8'hFF for a read cycle
//  dataout   out  8  last received byte, held until the next exchange completes
//  busy      out  1  exchange in progress
//  done      out  1  one-fclk pulse, last bit received
//  sdclk     out  1  SPI SCK to card
//  sdo       out  1  SPI MOSI to card
//  sdi       in   1  SPI MISO from card
// BEHAVIOUR
//  Clock and reset
//  - One clock (fclk); reset is asynchronous and active-low (rst_n). All state is reset by rst_n.
//  - Reset values: sdclk=0, sdo=1, dataout=8'hFF, busy=0, done=0, state=IDLE, counters=0.
//  - Reset mid-exchange aborts immediately to the reset values; there is no partial dataout update.
//  FSM: IDLE, LOW, HIGH
//  - IDLE: sdclk=0, sdo=1.
//    - start=1 with busy=0: latch datain into shreg, sdo<=datain[7], busy<=1, divcnt<=0, bitcnt<=0, go to LOW.
//  - LOW: sdclk=0. When divcnt reaches HALF_DIV-1:
//    - sdclk<=1 (rising edge); shreg<={shreg[6:0],sdi} (sample on the rising edge); go to HIGH.
//  - HIGH: sdclk=1. When divcnt reaches HALF_DIV-1:
//    - sdclk<=0 (falling edge).
//    - If bitcnt==7: dataout<=shreg, done<=1, busy<=0, sdo<=1, go to IDLE.
//    - Else: sdo<=shreg[7], bitcnt<=bitcnt+1, go to LOW.
//  - divcnt resets to 0 on every phase change; width = clog2(HALF_DIV), minimum 1 bit.
//  Timing and handshake
//  - Latency: start in cycle N gives done=1 in cycle N+16*HALF_DIV. Exactly 8 SCK pulses per exchange.
//  - sdo is stable for at least HALF_DIV cycles before each rising sdclk edge (mode 0 setup).
//  - start while busy=1 is ignored; no queueing, no datain re-latch.
//  - start in the same cycle as done (busy already 0) is accepted; the next exchange begins the following cycle.
//  - datain is sampled only on the accepted start cycle; it may change freely afterwards.
//  - done is high for exactly 1 cycle. dataout changes only on that cycle.
//  - sdi is sampled directly, with no synchronizer; SPI timing is source-synchronous.
// STRUCTURE
//  - Flat module; no sub-module required.
//  - Shared include sd_defs.vh holds:
//    - SD_IDLE_BYTE = 8'hFF
//    - FSM state encodings SPI_IDLE/SPI_LOW/SPI_HIGH (2-bit)
//  - The port decoder includes the same file for the read-cycle fill byte.
// TESTING
//  1. Reset: hold rst_n=0 mid-stream -> sdclk=0, sdo=1, dataout=FF, busy=0, done=0. Async response without fclk edge.
//  2. HALF_DIV=1, datain=8'hA5, card model returns 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1 on rising edges; done at start+16; dataout=8'h3C.
//  3. HALF_DIV=3, datain=8'hFF, sdi tied 0 -> 8 SCK pulses each 3 high/3 low; done at start+48; dataout=8'h00.
//  4. Second start pulse 5 cycles into an exchange -> ignored; a single done; sdclk pulse count stays 8.
//  5. Start in the same cycle as done -> new exchange begins the next cycle; back-to-back bytes 8'h12, 8'h34 both echoed by a loopback (sdo->sdi) model.
//  6. Assert rst_n=0 after 4 bits -> transfer aborted, dataout stays the previous value FF, done never pulses.

Source files
------------

// File: rtl/sd_spi_master_pkg.sv
// Shared definitions for the SD card SPI master: idle fill byte and FSM encodings.
package sd_spi_master_pkg;

   localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

   typedef enum logic [1:0] {
      SPI_IDLE = 2'd0,
      SPI_LOW  = 2'd1,
      SPI_HIGH = 2'd2
   } spi_state_e;

endpackage

// File: rtl/sd_spi_master.sv
// SPI mode 0 master, MSB first, one 8-bit exchange per start pulse.
// SCK half-period is HALF_DIV fclk cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SPI_IDLE | SCK low, MOSI high, waiting for start
// SPI_LOW  | SCK low half-period, MOSI holds the bit being set up
// SPI_HIGH | SCK high half-period, MISO bit already captured on rising edge
module sd_spi_master
   import sd_spi_master_pkg::*;
#(
   parameter int HALF_DIV = 1
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] datain,
   output logic [7:0] dataout,
   output logic       busy,
   output logic       done,
   output logic       sdclk,
   output logic       sdo,
   input  logic       sdi
);

   localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

   spi_state_e       state_q, state_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       dataout_q, dataout_d;
   logic [DIV_W-1:0] divcnt_q, divcnt_d;
   logic [2:0]       bitcnt_q, bitcnt_d;
   logic             sdclk_q, sdclk_d;
   logic             sdo_q, sdo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_end;

   assign div_end = (divcnt_q == DIV_LAST);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      dataout_d = dataout_q;
      divcnt_d  = divcnt_q;
      bitcnt_d  = bitcnt_q;
      sdclk_d   = sdclk_q;
      sdo_d     = sdo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         SPI_IDLE: begin
            sdclk_d = 1'b0;
            sdo_d   = 1'b1;
            if (start && !busy_q) begin
               shreg_d  = datain;
               sdo_d    = datain[7];
               busy_d   = 1'b1;
               divcnt_d = '0;
               bitcnt_d = 3'd0;
               state_d  = SPI_LOW;
            end
         end
         SPI_LOW: begin
            if (div_end) begin
               sdclk_d  = 1'b1;
               shreg_d  = {shreg_q[6:0], sdi};
               divcnt_d = '0;
               state_d  = SPI_HIGH;
            end else begin
               divcnt_d = divcnt_q + 1'b1;
            end
         end
         SPI_HIGH: begin
            if (div_end) begin
               sdclk_d  = 1'b0;
               divcnt_d = '0;
               if (bitcnt_q == 3'd7) begin
                  dataout_d = shreg_q;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  sdo_d     = 1'b1;
                  state_d   = SPI_IDLE;
               end else begin
                  // shreg has already shifted once, so [7] is the next bit to send
                  sdo_d    = shreg_q[7];
                  bitcnt_d = bitcnt_q + 3'd1;
                  state_d  = SPI_LOW;
               end
            end else begin
               divcnt_d = divcnt_q + 1'b1;
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SPI_IDLE;
         shreg_q   <= '0;
         dataout_q <= SD_IDLE_BYTE;
         divcnt_q  <= '0;
         bitcnt_q  <= 3'd0;
         sdclk_q   <= 1'b0;
         sdo_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         dataout_q <= dataout_d;
         divcnt_q  <= divcnt_d;
         bitcnt_q  <= bitcnt_d;
         sdclk_q   <= sdclk_d;
         sdo_q     <= sdo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign dataout = dataout_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign sdclk   = sdclk_q;
   assign sdo     = sdo_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: HALF_DIV=1 and HALF_DIV=3 instances, MOSI and dataout scoreboards.
module tb_sd_spi_master;
   import sd_spi_master_pkg::*;

   logic fclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 fclk = ~fclk;

   logic       start1 = 1'b0, start3 = 1'b0;
   logic [7:0] din1 = 8'h00, din3 = 8'h00;
   logic [7:0] dout1, dout3;
   logic       busy1, busy3, done1, done3, sclk1, sclk3, sdo1, sdo3;
   logic       sdi1;
   logic       sdi3 = 1'b0;

   sd_spi_master #(.HALF_DIV(1)) dut1 (
      .fclk(fclk), .rst_n(rst_n), .start(start1), .datain(din1), .dataout(dout1),
      .busy(busy1), .done(done1), .sdclk(sclk1), .sdo(sdo1), .sdi(sdi1));

   sd_spi_master #(.HALF_DIV(3)) dut3 (
      .fclk(fclk), .rst_n(rst_n), .start(start3), .datain(din3), .dataout(dout3),
      .busy(busy3), .done(done3), .sdclk(sclk3), .sdo(sdo3), .sdi(sdi3));

   int n_pass = 0;
   int n_total = 0;

   logic       mosi1_q[$];
   logic       mosi3_q[$];
   logic [7:0] dout1_q[$];
   logic [7:0] dout3_q[$];

   int rise1_cnt = 0, rise3_cnt = 0, done1_cnt = 0, done3_cnt = 0;
   logic sclk1_prev = 1'b0, sclk3_prev = 1'b0;

   // card model: 0 = shift card_byte out (changes after each rising edge), 2 = loopback
   int         card_mode = 0;
   logic [7:0] card_byte = 8'hFF;
   int         base1 = 0;
   logic       card_bit;

   always_comb begin
      int k;
      k = rise1_cnt - base1;
      card_bit = 1'b1;
      if (k >= 0 && k < 8) card_bit = card_byte[7-k];
   end
   assign sdi1 = (card_mode == 2) ? sdo1 : card_bit;

   always @(negedge fclk) begin
      logic       eb;
      logic [7:0] ed;
      if (sclk1 && !sclk1_prev) begin
         rise1_cnt++;
         n_total++;
         if (mosi1_q.size() == 0) $display("FAIL mosi1: unexpected SCK rise, sdo=%0b", sdo1);
         else begin
            eb = mosi1_q.pop_front();
            if (sdo1 !== eb) $display("FAIL mosi1: sdo=%0b required %0b", sdo1, eb);
            else n_pass++;
         end
      end
      sclk1_prev <= sclk1;
      if (sclk3 && !sclk3_prev) begin
         rise3_cnt++;
         n_total++;
         if (mosi3_q.size() == 0) $display("FAIL mosi3: unexpected SCK rise, sdo=%0b", sdo3);
         else begin
            eb = mosi3_q.pop_front();
            if (sdo3 !== eb) $display("FAIL mosi3: sdo=%0b required %0b", sdo3, eb);
            else n_pass++;
         end
      end
      sclk3_prev <= sclk3;
      if (done1 === 1'b1) begin
         done1_cnt++;
         n_total++;
         if (dout1_q.size() == 0) $display("FAIL dout1: unexpected done, dataout=%h", dout1);
         else begin
            ed = dout1_q.pop_front();
            if (dout1 !== ed) $display("FAIL dout1: dataout=%h required %h", dout1, ed);
            else n_pass++;
         end
      end
      if (done3 === 1'b1) begin
         done3_cnt++;
         n_total++;
         if (dout3_q.size() == 0) $display("FAIL dout3: unexpected done, dataout=%h", dout3);
         else begin
            ed = dout3_q.pop_front();
            if (dout3 !== ed) $display("FAIL dout3: dataout=%h required %h", dout3, ed);
            else n_pass++;
         end
      end
   end

   task automatic push_mosi1(input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++) mosi1_q.push_back(b[7-i]);
   endtask

   // Drives start at the current negedge; returns negedges until done (-1 on timeout).
   task automatic xfer1(input logic [7:0] d, output int lat);
      lat = -1;
      din1 = d; start1 = 1'b1; base1 = rise1_cnt;
      for (int c = 1; c <= 60; c++) begin
         @(negedge fclk);
         if (c == 1) begin start1 = 1'b0; din1 = ~d; end
         if (done1 === 1'b1) begin lat = c; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge fclk);
      rst_n = 1'b1;
      repeat (2) @(negedge fclk);
      card_mode = 0; card_byte = 8'h3C;
      push_mosi1(8'hA5, 2);
      din1 = 8'hA5; start1 = 1'b1; base1 = rise1_cnt;
      for (int c = 1; c <= 5; c++) begin
         @(negedge fclk);
         if (c == 1) start1 = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (sclk1 !== 1'b0) $display("FAIL rst_sdclk: %b required 0", sclk1); else n_pass++;
      n_total++; if (sdo1 !== 1'b1) $display("FAIL rst_sdo: %b required 1", sdo1); else n_pass++;
      n_total++; if (dout1 !== SD_IDLE_BYTE) $display("FAIL rst_dataout: %h required ff", dout1); else n_pass++;
      n_total++; if (busy1 !== 1'b0) $display("FAIL rst_busy: %b required 0", busy1); else n_pass++;
      n_total++; if (done1 !== 1'b0) $display("FAIL rst_done: %b required 0", done1); else n_pass++;
      n_total++; if (sdo3 !== 1'b1 || dout3 !== 8'hFF) $display("FAIL rst_dut3: sdo=%b dataout=%h required 1 ff", sdo3, dout3); else n_pass++;
      repeat (2) @(negedge fclk);
      rst_n = 1'b1;
      @(negedge fclk);
   endtask

   task automatic test_hd1_a5();
      int lat, r0;
      card_mode = 0; card_byte = 8'h3C;
      push_mosi1(8'hA5, 8);
      dout1_q.push_back(8'h3C);
      r0 = rise1_cnt;
      @(negedge fclk);
      xfer1(8'hA5, lat);
      n_total++; if (lat != 17) $display("FAIL hd1_latency: done after %0d required 17", lat); else n_pass++;
      n_total++; if (rise1_cnt - r0 != 8) $display("FAIL hd1_pulses: %0d required 8", rise1_cnt - r0); else n_pass++;
      @(negedge fclk);
      n_total++; if (done1 !== 1'b0) $display("FAIL hd1_done_width: done=%b required 0", done1); else n_pass++;
      n_total++; if (dout1 !== 8'h3C || busy1 !== 1'b0 || sdo1 !== 1'b1)
         $display("FAIL hd1_after: dataout=%h busy=%b sdo=%b required 3c 0 1", dout1, busy1, sdo1);
      else n_pass++;
   endtask

   task automatic test_hd3_ff();
      int lat, hi_run, lo_run, bad, pulses;
      lat = -1; hi_run = 0; lo_run = 0; bad = 0; pulses = 0;
      for (int i = 0; i < 8; i++) mosi3_q.push_back(1'b1);
      dout3_q.push_back(8'h00);
      @(negedge fclk);
      din3 = 8'hFF; start3 = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge fclk);
         if (c == 1) begin start3 = 1'b0; din3 = 8'h00; end
         if (sclk3) begin
            if (hi_run == 0) begin
               pulses++;
               if (lo_run != 3) bad++;
            end
            hi_run++; lo_run = 0;
         end else begin
            if (hi_run != 0 && hi_run != 3) bad++;
            hi_run = 0; lo_run++;
         end
         if (done3 === 1'b1) begin lat = c; break; end
      end
      n_total++; if (lat != 49) $display("FAIL hd3_latency: done after %0d required 49", lat); else n_pass++;
      n_total++; if (pulses != 8) $display("FAIL hd3_pulses: %0d required 8", pulses); else n_pass++;
      n_total++; if (bad != 0) $display("FAIL hd3_phase_width: %0d bad half-periods required 0", bad); else n_pass++;
      @(negedge fclk);
      n_total++; if (dout3 !== 8'h00 || done3 !== 1'b0) $display("FAIL hd3_after: dataout=%h done=%b required 00 0", dout3, done3); else n_pass++;
   endtask

   task automatic test_ignore_start();
      int r0, d0;
      card_mode = 0; card_byte = 8'hC3;
      push_mosi1(8'h5A, 8);
      dout1_q.push_back(8'hC3);
      r0 = rise1_cnt; d0 = done1_cnt;
      @(negedge fclk);
      din1 = 8'h5A; start1 = 1'b1; base1 = rise1_cnt;
      for (int c = 1; c <= 40; c++) begin
         @(negedge fclk);
         if (c == 1) begin start1 = 1'b0; din1 = 8'h00; end
         if (c == 5) start1 = 1'b1;
         if (c == 6) start1 = 1'b0;
      end
      n_total++; if (done1_cnt - d0 != 1) $display("FAIL ignore_done_count: %0d required 1", done1_cnt - d0); else n_pass++;
      n_total++; if (rise1_cnt - r0 != 8) $display("FAIL ignore_pulses: %0d required 8", rise1_cnt - r0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat;
      card_mode = 2;
      push_mosi1(8'h12, 8);
      push_mosi1(8'h34, 8);
      dout1_q.push_back(8'h12);
      dout1_q.push_back(8'h34);
      @(negedge fclk);
      xfer1(8'h12, lat);
      n_total++; if (lat != 17) $display("FAIL b2b_first_latency: %0d required 17", lat); else n_pass++;
      // done is high right now; start in this same cycle must be accepted
      din1 = 8'h34; start1 = 1'b1;
      @(negedge fclk);
      start1 = 1'b0; din1 = 8'h00;
      n_total++; if (busy1 !== 1'b1 || sclk1 !== 1'b0) $display("FAIL b2b_accept: busy=%b sdclk=%b required 1 0", busy1, sclk1); else n_pass++;
      lat = -1;
      for (int c = 2; c <= 60; c++) begin
         @(negedge fclk);
         if (done1 === 1'b1) begin lat = c; break; end
      end
      n_total++; if (lat != 17) $display("FAIL b2b_second_latency: %0d required 17", lat); else n_pass++;
      @(negedge fclk);
      card_mode = 0;
   endtask

   task automatic test_abort();
      int r0, d0;
      rst_n = 1'b0;
      repeat (2) @(negedge fclk);
      rst_n = 1'b1;
      @(negedge fclk);
      card_mode = 0; card_byte = 8'h3C;
      push_mosi1(8'hA5, 4);
      r0 = rise1_cnt; d0 = done1_cnt;
      din1 = 8'hA5; start1 = 1'b1; base1 = rise1_cnt;
      for (int c = 1; c <= 8; c++) begin
         @(negedge fclk);
         if (c == 1) start1 = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (rise1_cnt - r0 != 4) $display("FAIL abort_bits_before: %0d required 4", rise1_cnt - r0); else n_pass++;
      n_total++; if (dout1 !== 8'hFF || busy1 !== 1'b0 || sclk1 !== 1'b0)
         $display("FAIL abort_state: dataout=%h busy=%b sdclk=%b required ff 0 0", dout1, busy1, sclk1);
      else n_pass++;
      repeat (2) @(negedge fclk);
      rst_n = 1'b1;
      repeat (30) @(negedge fclk);
      n_total++; if (done1_cnt != d0) $display("FAIL abort_no_done: %0d done pulses required 0", done1_cnt - d0); else n_pass++;
      n_total++; if (dout1 !== 8'hFF) $display("FAIL abort_dataout: %h required ff", dout1); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hd1_a5();
      test_hd3_ff();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      n_total++; if (mosi1_q.size() != 0) $display("FAIL mosi1_leftover: %0d bits required 0", mosi1_q.size()); else n_pass++;
      n_total++; if (mosi3_q.size() != 0) $display("FAIL mosi3_leftover: %0d bits required 0", mosi3_q.size()); else n_pass++;
      n_total++; if (dout1_q.size() != 0) $display("FAIL dout1_leftover: %0d bytes required 0", dout1_q.size()); else n_pass++;
      n_total++; if (dout3_q.size() != 0) $display("FAIL dout3_leftover: %0d bytes required 0", dout3_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
